// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: memory op codes, FSM state
// encoding, bus/register widths and op classification helpers.
package mem_stage_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_OP_W   = 4;

    localparam logic [REG_W-1:0]      ZERO_WORD = 32'h0000_0000;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = 5'd0;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: is_load = 1'b1;
            default:                                  is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
            default:                is_store = 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words a multiple of four; bytes always fit.
    function automatic logic is_aligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] off);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: is_aligned = (off[0] == 1'b0);
            MEM_LW, MEM_SW:          is_aligned = (off == 2'b00);
            default:                 is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Load/store lane alignment for the MEM stage (purely combinational).
//   op     : memory op code
//   off    : byte offset within the word (addr[1:0])
//   sdata  : store data (rs2)
//   rdata  : raw read word from the data bus
//   be     : byte enables for the access (loads and stores)
//   wdata  : lane-replicated store data (zero for loads)
//   ldata  : extracted, sign/zero-extended load result
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [MEM_OP_W-1:0] op,
    input  logic [1:0]          off,
    input  logic [REG_W-1:0]    sdata,
    input  logic [REG_W-1:0]    rdata,
    output logic [3:0]          be,
    output logic [REG_W-1:0]    wdata,
    output logic [REG_W-1:0]    ldata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes of the read word
    always_comb begin
        case (off)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Byte enables, replicated store data and extended load data per op
    always_comb begin
        be    = 4'b0000;
        wdata = ZERO_WORD;
        ldata = ZERO_WORD;
        case (op)
            MEM_LB: begin
                be    = 4'b0001 << off;
                ldata = {{24{byte_s[7]}}, byte_s};
            end
            MEM_LBU: begin
                be    = 4'b0001 << off;
                ldata = {24'h00_0000, byte_s};
            end
            MEM_LH: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                ldata = {{16{half_s[15]}}, half_s};
            end
            MEM_LHU: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                ldata = {16'h0000, half_s};
            end
            MEM_LW: begin
                be    = 4'b1111;
                ldata = rdata;
            end
            MEM_SB: begin
                be    = 4'b0001 << off;
                wdata = {4{sdata[7:0]}};
            end
            MEM_SH: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sdata[15:0]}};
            end
            MEM_SW: begin
                be    = 4'b1111;
                wdata = sdata;
            end
            default: begin
                be    = 4'b0000;
                wdata = ZERO_WORD;
                ldata = ZERO_WORD;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage between exe_mem and mem_wb.
// Non-memory ops pass writeback fields straight through. Aligned loads/stores
// run one request/ack transaction on the data bus while stalling upstream;
// misaligned accesses and bus timeouts are dropped and reported as pulses.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   reg_waddr_i/we_i/wdata_i       writeback fields from exe_mem
//   mem_op_i, mem_addr_i, mem_sdata_i  memory op, effective address, store data
//   reg_waddr_o/we_o/wdata_o       writeback fields to mem_wb (combinational)
//   dbus_*_o                       registered data-bus request
//   dbus_rdata_i, dbus_ack_i       data-bus response
//   stall_req_o                    freeze earlier pipeline stages
//   misalign_o, bus_err_o          one-cycle error pulses
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [REG_W-1:0]      reg_wdata_i,
    input  logic [MEM_OP_W-1:0]   mem_op_i,
    input  logic [REG_W-1:0]      mem_addr_i,
    input  logic [REG_W-1:0]      mem_sdata_i,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic                  reg_we_o,
    output logic [REG_W-1:0]      reg_wdata_o,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [REG_W-1:0]      dbus_addr_o,
    output logic [3:0]            dbus_be_o,
    output logic [REG_W-1:0]      dbus_wdata_o,
    input  logic [REG_W-1:0]      dbus_rdata_i,
    input  logic                  dbus_ack_i,
    output logic                  stall_req_o,
    output logic                  misalign_o,
    output logic                  bus_err_o
);

    state_e                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [REG_ADDR_W-1:0] cap_waddr_r;
    logic                  cap_we_r;
    logic [MEM_OP_W-1:0]   cap_op_r;
    logic [1:0]            cap_off_r;

    logic [MEM_OP_W-1:0]   al_op_s;
    logic [1:0]            al_off_s;
    logic [3:0]            al_be_s;
    logic [REG_W-1:0]      al_wdata_s;
    logic [REG_W-1:0]      al_ldata_s;
    logic                  in_mem_s;
    logic                  in_aligned_s;
    logic                  start_s;
    logic                  timeout_s;

    // The aligner formats the live request in IDLE and the captured access in WAIT
    always_comb begin
        if (state_r == ST_WAIT) begin
            al_op_s  = cap_op_r;
            al_off_s = cap_off_r;
        end else begin
            al_op_s  = mem_op_i;
            al_off_s = mem_addr_i[1:0];
        end
    end

    mem_stage_lsu_align u_align (
        .op    (al_op_s),
        .off   (al_off_s),
        .sdata (mem_sdata_i),
        .rdata (dbus_rdata_i),
        .be    (al_be_s),
        .wdata (al_wdata_s),
        .ldata (al_ldata_s)
    );

    // Classify the incoming op and detect the timeout cycle (ack beats timeout)
    always_comb begin
        in_mem_s     = is_load(mem_op_i) | is_store(mem_op_i);
        in_aligned_s = is_aligned(mem_op_i, mem_addr_i[1:0]);
        start_s      = (state_r == ST_IDLE) && in_mem_s && in_aligned_s;
        if (TIMEOUT_CYC == 0) begin
            timeout_s = 1'b0;
        end else begin
            timeout_s = (state_r == ST_WAIT) && !dbus_ack_i
                        && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
        end
    end

    // Writeback, stall and error pulses are combinational from state and inputs
    always_comb begin
        reg_waddr_o = ZERO_REG;
        reg_we_o    = 1'b0;
        reg_wdata_o = ZERO_WORD;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        if (rst_i) begin
            reg_we_o = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!in_mem_s) begin
                        reg_waddr_o = reg_waddr_i;
                        reg_we_o    = reg_we_i;
                        reg_wdata_o = reg_wdata_i;
                    end else if (!in_aligned_s) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_req_o = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dbus_ack_i) begin
                        if (is_load(cap_op_r)) begin
                            reg_waddr_o = cap_waddr_r;
                            reg_we_o    = cap_we_r;
                            reg_wdata_o = al_ldata_s;
                        end else begin
                            reg_we_o = 1'b0;
                        end
                    end else if (timeout_s) begin
                        bus_err_o = 1'b1;
                    end else begin
                        stall_req_o = 1'b1;
                    end
                end
                default: begin
                    reg_we_o = 1'b0;
                end
            endcase
        end
    end

    // IDLE/WAIT state machine with the registered bus request and captured access
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            cap_waddr_r  <= ZERO_REG;
            cap_we_r     <= 1'b0;
            cap_op_r     <= MEM_NOP;
            cap_off_r    <= 2'b00;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= ZERO_WORD;
            dbus_be_o    <= 4'b0000;
            dbus_wdata_o <= ZERO_WORD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r      <= ST_WAIT;
                        cnt_r        <= '0;
                        cap_waddr_r  <= reg_waddr_i;
                        cap_we_r     <= reg_we_i;
                        cap_op_r     <= mem_op_i;
                        cap_off_r    <= mem_addr_i[1:0];
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= is_store(mem_op_i);
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_be_o    <= al_be_s;
                        dbus_wdata_o <= al_wdata_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (dbus_ack_i || timeout_s) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= '0;
                        dbus_req_o <= 1'b0;
                        dbus_we_o  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= '0;
                    dbus_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
